// File: rtl/flow_arbiter_pkg.sv
// Shared constants for the two-source phrase arbiter: FSM encoding, abort byte, source IDs.
// Also defines the packed beat record held in the output register.
package flow_arbiter_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_GRANT0 = 2'd1;
    localparam logic [1:0] ST_GRANT1 = 2'd2;
    localparam logic [1:0] ST_FLUSH  = 2'd3;

    localparam logic [7:0] ABORT_CHAR = 8'h00;

    localparam logic SRC0 = 1'b0;
    localparam logic SRC1 = 1'b1;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       src;
        logic       abort;
    } beat_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick, purely combinational; on a tie the source that was
// not served last (ptr) wins.
module rr_pick2
    import flow_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] grant
);

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = (ptr == SRC1) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/flow_arbiter.sv
// Grants whole phrases from two sources onto one registered stream (1-cycle latency).
// Source ready follows output-register space; a silent granted source is aborted after TIMEOUT cycles.
module flow_arbiter
    import flow_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s0_valid,
    input  logic [7:0]       s0_data,
    input  logic             s0_last,
    output logic             s0_ready,
    input  logic             s1_valid,
    input  logic [7:0]       s1_data,
    input  logic             s1_last,
    output logic             s1_ready,
    output logic             m_valid,
    output logic [7:0]       m_data,
    output logic             m_last,
    output logic             m_src,
    output logic             m_abort,
    input  logic             m_ready,
    output logic [CNT_W-1:0] pkt_cnt0,
    output logic [CNT_W-1:0] pkt_cnt1,
    output logic             err_timeout
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    logic [1:0]       state_q, state_d;
    logic             ptr_q, ptr_d;
    logic             src_q, src_d;
    logic             out_vld_q, out_vld_d;
    beat_t            out_q, out_d;
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;
    logic             err_q, err_d;
    logic [7:0]       to_q, to_d;

    logic [1:0]       grant;
    logic             out_free;
    logic             cur_vld;
    logic             acc;
    beat_t            in_beat;

    rr_pick2 u_pick (
        .req   ({s1_valid, s0_valid}),
        .ptr   (ptr_q),
        .grant (grant)
    );

    assign out_free = !out_vld_q || m_ready;
    assign s0_ready = (state_q == ST_GRANT0) && out_free;
    assign s1_ready = (state_q == ST_GRANT1) && out_free;
    assign cur_vld  = (src_q == SRC1) ? s1_valid : s0_valid;
    assign acc      = (s0_ready && s0_valid) || (s1_ready && s1_valid);

    always_comb begin
        in_beat = '{data: s0_data, last: s0_last, src: SRC0, abort: 1'b0};
        if (src_q == SRC1) begin
            in_beat = '{data: s1_data, last: s1_last, src: SRC1, abort: 1'b0};
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        src_d     = src_q;
        out_vld_d = out_vld_q && !m_ready;
        out_d     = out_q;
        cnt0_d    = cnt0_q;
        cnt1_d    = cnt1_q;
        err_d     = err_q;
        to_d      = to_q;
        case (state_q)
            ST_IDLE: begin
                to_d = '0;
                if (grant[0]) begin
                    state_d = ST_GRANT0;
                    src_d   = SRC0;
                end else if (grant[1]) begin
                    state_d = ST_GRANT1;
                    src_d   = SRC1;
                end
            end
            ST_GRANT0, ST_GRANT1: begin
                if (acc) begin
                    out_vld_d = 1'b1;
                    out_d     = in_beat;
                    to_d      = '0;
                    if (in_beat.last) begin
                        state_d = ST_IDLE;
                        ptr_d   = src_q;
                        if (src_q == SRC1) begin
                            cnt1_d = (cnt1_q == '1) ? cnt1_q : cnt1_q + 1'b1;
                        end else begin
                            cnt0_d = (cnt0_q == '1) ? cnt0_q : cnt0_q + 1'b1;
                        end
                    end
                end else if (!cur_vld) begin
                    // Only source silence counts; a downstream stall keeps the counter frozen.
                    if (to_q == TO_LAST) begin
                        state_d = ST_FLUSH;
                    end else begin
                        to_d = to_q + 1'b1;
                    end
                end
            end
            ST_FLUSH: begin
                if (out_free) begin
                    out_vld_d = 1'b1;
                    out_d     = '{data: ABORT_CHAR, last: 1'b1, src: src_q, abort: 1'b1};
                    err_d     = 1'b1;
                    ptr_d     = src_q;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= SRC1;
            src_q     <= SRC0;
            out_vld_q <= 1'b0;
            out_q     <= '0;
            cnt0_q    <= '0;
            cnt1_q    <= '0;
            err_q     <= 1'b0;
            to_q      <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            src_q     <= src_d;
            out_vld_q <= out_vld_d;
            out_q     <= out_d;
            cnt0_q    <= cnt0_d;
            cnt1_q    <= cnt1_d;
            err_q     <= err_d;
            to_q      <= to_d;
        end
    end

    assign m_valid     = out_vld_q;
    assign m_data      = out_q.data;
    assign m_last      = out_q.last;
    assign m_src       = out_q.src;
    assign m_abort     = out_q.abort;
    assign pkt_cnt0    = cnt0_q;
    assign pkt_cnt1    = cnt1_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_flow_arbiter.sv
// Directed bench: per-cycle vector table for streaming, tie and stall cases, then
// hand-written sequences for timeout, threshold coincidence, mid-phrase reset and saturation.
module tb_flow_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s0_valid = 1'b0, s0_last = 1'b0, s0_ready;
    logic [7:0] s0_data = 8'h00;
    logic       s1_valid = 1'b0, s1_last = 1'b0, s1_ready;
    logic [7:0] s1_data = 8'h00;
    logic       m_valid, m_last, m_src, m_abort;
    logic [7:0] m_data;
    logic       m_ready = 1'b1;
    logic [7:0] pkt_cnt0, pkt_cnt1;
    logic       err_timeout;

    always #5 clk = ~clk;

    flow_arbiter #(.TIMEOUT(16), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .s0_valid(s0_valid), .s0_data(s0_data), .s0_last(s0_last), .s0_ready(s0_ready),
        .s1_valid(s1_valid), .s1_data(s1_data), .s1_last(s1_last), .s1_ready(s1_ready),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_src(m_src),
        .m_abort(m_abort), .m_ready(m_ready),
        .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1), .err_timeout(err_timeout)
    );

    typedef struct {
        bit         chk;
        bit         rst;
        bit         s0v;
        logic [7:0] s0d;
        bit         s0l;
        bit         s1v;
        logic [7:0] s1d;
        bit         s1l;
        bit         mr;
        bit         er0;
        bit         er1;
        bit         emv;
        logic [7:0] emd;
        bit         eml;
        bit         ems;
        bit         ema;
        logic [7:0] ec0;
        logic [7:0] ec1;
        bit         eerr;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] ily [8];
    int         checks = 0;
    int         errors = 0;
    int         k;
    int         acc;
    bit         seen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input bit c, r, v0, input logic [7:0] d0, input bit l0,
                       input bit v1, input logic [7:0] d1, input bit l1, input bit mr,
                       input bit r0, r1, mv, input logic [7:0] md, input bit ml, ms, ma,
                       input logic [7:0] c0, c1, input bit er);
        vec_t v;
        v = '{chk: c, rst: r, s0v: v0, s0d: d0, s0l: l0, s1v: v1, s1d: d1, s1l: l1, mr: mr,
              er0: r0, er1: r1, emv: mv, emd: md, eml: ml, ems: ms, ema: ma,
              ec0: c0, ec1: c1, eerr: er};
        vecs.push_back(v);
    endtask

    task automatic do_reset();
        rst = 1'b1; s0_valid = 1'b0; s1_valid = 1'b0; s0_last = 1'b0; s1_last = 1'b0; m_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Offers one beat and returns at the start of the cycle after it was taken.
    task automatic push(input bit src, input logic [7:0] d, input bit last);
        bit done;
        done = 1'b0;
        if (src) begin s1_valid = 1'b1; s1_data = d; s1_last = last; end
        else     begin s0_valid = 1'b1; s0_data = d; s0_last = last; end
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            done = src ? s1_ready : s0_ready;
            @(posedge clk); #1;
        end
        if (src) s1_valid = 1'b0; else s0_valid = 1'b0;
        chk("push_accept", {31'd0, done}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ily = '{"I", "L", "O", "V", "E", "Y", "O", "U"};
        // chk rst | s0 v d l | s1 v d l | mr | r0 r1 | mv md ml ms ma | c0 c1 err
        add(0,1, 0,0,0, 0,0,0, 1, 0,0, 0,0,0,0,0, 0,0,0);
        add(1,0, 0,0,0, 0,0,0, 1, 0,0, 0,0,0,0,0, 0,0,0);
        add(1,0, 1,ily[0],0, 0,0,0, 1, 0,0, 0,0,0,0,0, 0,0,0);
        for (int i = 1; i <= 8; i++)
            add(1,0, 1,ily[i-1],(i == 8), 0,0,0, 1, 1,0,
                (i >= 2), ily[(i >= 2) ? i-2 : 0],0,0,0, 0,0,0);
        add(1,0, 0,0,0, 0,0,0, 1, 0,0, 1,"U",1,0,0, 1,0,0);
        add(1,0, 0,0,0, 0,0,0, 1, 0,0, 0,0,0,0,0, 1,0,0);
        add(0,1, 0,0,0, 0,0,0, 1, 0,0, 0,0,0,0,0, 0,0,0);
        add(1,0, 0,0,0, 0,0,0, 1, 0,0, 0,0,0,0,0, 0,0,0);
        // both sources contend right after reset
        add(1,0, 1,"A",0, 1,"x",0, 1, 0,0, 0,0,0,0,0, 0,0,0);
        add(1,0, 1,"A",0, 1,"x",0, 1, 1,0, 0,0,0,0,0, 0,0,0);
        add(1,0, 1,"B",0, 1,"x",0, 1, 1,0, 1,"A",0,0,0, 0,0,0);
        add(1,0, 1,"C",1, 1,"x",0, 1, 1,0, 1,"B",0,0,0, 0,0,0);
        add(1,0, 0,0,0,   1,"x",0, 1, 0,0, 1,"C",1,0,0, 1,0,0);
        add(1,0, 0,0,0,   1,"x",0, 1, 0,1, 0,0,0,0,0,   1,0,0);
        add(1,0, 0,0,0,   1,"y",0, 1, 0,1, 1,"x",0,1,0, 1,0,0);
        add(1,0, 0,0,0,   1,"z",1, 1, 0,1, 1,"y",0,1,0, 1,0,0);
        add(1,0, 0,0,0,   0,0,0,   1, 0,0, 1,"z",1,1,0, 1,1,0);
        add(1,0, 0,0,0,   0,0,0,   1, 0,0, 0,0,0,0,0,   1,1,0);
        // downstream stall pattern 1,0,0,1 mid-phrase
        add(1,0, 1,"D",0, 0,0,0, 1, 0,0, 0,0,0,0,0,   1,1,0);
        add(1,0, 1,"D",0, 0,0,0, 1, 1,0, 0,0,0,0,0,   1,1,0);
        add(1,0, 1,"E",0, 0,0,0, 0, 0,0, 1,"D",0,0,0, 1,1,0);
        add(1,0, 1,"E",0, 0,0,0, 0, 0,0, 1,"D",0,0,0, 1,1,0);
        add(1,0, 1,"E",0, 0,0,0, 1, 1,0, 1,"D",0,0,0, 1,1,0);
        add(1,0, 1,"F",1, 0,0,0, 1, 1,0, 1,"E",0,0,0, 1,1,0);
        add(1,0, 0,0,0,   0,0,0, 1, 0,0, 1,"F",1,0,0, 2,1,0);
        add(1,0, 0,0,0,   0,0,0, 1, 0,0, 0,0,0,0,0,   2,1,0);

        foreach (vecs[i]) begin
            rst = vecs[i].rst;
            s0_valid = vecs[i].s0v; s0_data = vecs[i].s0d; s0_last = vecs[i].s0l;
            s1_valid = vecs[i].s1v; s1_data = vecs[i].s1d; s1_last = vecs[i].s1l;
            m_ready = vecs[i].mr;
            @(negedge clk);
            if (vecs[i].chk) begin
                chk($sformatf("vec%0d_ctl", i),
                    {12'd0, s0_ready, s1_ready, m_valid, err_timeout, pkt_cnt0, pkt_cnt1},
                    {12'd0, vecs[i].er0, vecs[i].er1, vecs[i].emv, vecs[i].eerr, vecs[i].ec0, vecs[i].ec1});
                if (vecs[i].emv)
                    chk($sformatf("vec%0d_beat", i), {21'd0, m_data, m_last, m_src, m_abort},
                        {21'd0, vecs[i].emd, vecs[i].eml, vecs[i].ems, vecs[i].ema});
            end
            @(posedge clk); #1;
        end

        // Timeout abort of source 1 after the pointer was left on source 0
        do_reset();
        push(0, "K", 1);
        push(1, "l", 0);
        push(1, "o", 0);
        k = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (m_valid && m_abort) begin k = n; break; end
            @(posedge clk); #1;
        end
        chk("abort_delay", k, 18);
        chk("abort_beat", {21'd0, m_valid, m_data, m_last, m_src, m_abort},
            {21'd0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1});
        chk("abort_err", {31'd0, err_timeout}, 32'd1);
        chk("abort_cnt1", {24'd0, pkt_cnt1}, 32'd0);
        @(posedge clk); #1;
        s0_valid = 1'b1; s0_data = "Z"; s0_last = 1'b1;
        s1_valid = 1'b1; s1_data = "q"; s1_last = 1'b1;
        @(negedge clk);
        chk("idle_ready", {30'd0, s0_ready, s1_ready}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rr_after_abort", {30'd0, s0_ready, s1_ready}, 32'd2);
        @(posedge clk); #1;
        s0_valid = 1'b0;
        push(1, "q", 1);
        @(negedge clk);
        chk("cnt1_after_q", {24'd0, pkt_cnt1}, 32'd1);
        @(posedge clk); #1;

        // Source returns exactly on the threshold cycle: beat taken, no abort
        push(1, "a", 0);
        repeat (15) begin @(posedge clk); #1; end
        s1_valid = 1'b1; s1_data = "b"; s1_last = 1'b1;
        @(negedge clk);
        chk("thresh_accept", {31'd0, s1_ready}, 32'd1);
        @(posedge clk); #1;
        s1_valid = 1'b0;
        @(negedge clk);
        chk("thresh_beat", {21'd0, m_valid, m_data, m_last, m_src, m_abort},
            {21'd0, 1'b1, 8'h62, 1'b1, 1'b1, 1'b0});
        chk("thresh_cnt1", {24'd0, pkt_cnt1}, 32'd2);
        chk("err_sticky", {31'd0, err_timeout}, 32'd1);
        @(posedge clk); #1;

        // Reset while the third beat of a phrase is offered
        push(0, "A", 0);
        push(0, "B", 0);
        s0_valid = 1'b1; s0_data = "C"; s0_last = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; s0_valid = 1'b0;
        @(negedge clk);
        chk("rst_outputs", {17'd0, s0_ready, s1_ready, m_valid, m_data, m_last, m_src, m_abort, err_timeout},
            32'd0);
        chk("rst_counters", {16'd0, pkt_cnt0, pkt_cnt1}, 32'd0);
        seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (m_valid) seen = 1'b1;
        end
        chk("rst_no_abort", {31'd0, seen}, 32'd0);
        @(posedge clk); #1;

        // 300 one-beat phrases from source 0
        s0_valid = 1'b1; s0_data = 8'h2e; s0_last = 1'b1;
        acc = 0;
        for (int n = 0; n < 1000 && acc < 300; n++) begin
            @(negedge clk);
            if (s0_ready) acc++;
            @(posedge clk); #1;
        end
        s0_valid = 1'b0;
        chk("sat_accepted", acc, 300);
        @(negedge clk);
        chk("sat_cnt0", {24'd0, pkt_cnt0}, 32'd255);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/flow_arbiter.md
FLOW_ARBITER -- requirements
Module: flow_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning the number of consecutive idle granted cycles before the packet is aborted (range 2..255).
REQ-002 SHALL have parameter CNT_W, default 8, meaning the width of each packet counter.
REQ-003 SHALL have port clk  input  1  single clock, with all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port s0_valid/s0_data/s0_last  input  1/8/1  source 0: uppercase character stream, ASCII byte, end-of-phrase.
REQ-006 SHALL have port s0_ready  output  1  source 0 beat accepted when s0_valid&&s0_ready.
REQ-007 SHALL have port s1_valid/s1_data/s1_last  input  1/8/1  source 1: lowercase character stream, same meaning as source 0.
REQ-008 SHALL have port s1_ready  output  1  source 1 accept.
REQ-009 SHALL have port m_valid/m_data/m_last/m_src/m_abort  output  1/8/1/1/1  stream to the shared phrase detector; m_src gives the originating source.
REQ-010 SHALL have port m_ready  input  1  detector accepts when m_valid&&m_ready.
REQ-011 SHALL have port pkt_cnt0/pkt_cnt1  output  CNT_W/CNT_W  completed phrases per source.
REQ-012 SHALL have port err_timeout  output  1  sticky flag, set on any abort.

Function
REQ-013 SHALL share one detector between two sources, granting whole phrases (first beat through the s*_last beat) with no interleaving.
REQ-014 SHALL implement FSM states IDLE, GRANT0, GRANT1 and FLUSH.
REQ-015 IDLE: SHALL go to GRANT of the only valid source; if both are valid, SHALL grant the source not granted last (round-robin pointer); if neither is valid, SHALL stay in IDLE.
REQ-016 SHALL keep s*_ready low in IDLE and FLUSH; in GRANTx, SHALL drive sx_ready = (!m_valid || m_ready) and the other source's ready = 0.
REQ-017 SHALL register the output: a beat accepted in cycle N SHALL appear on m_* in cycle N+1, giving a 1-cycle latency and full throughput under continuous m_ready.
REQ-018 SHALL hold m_* stable while m_valid && !m_ready.
REQ-019 On acceptance of a beat with last=1 in GRANTx, SHALL go to IDLE, update the pointer to x, and increment pkt_cntx.
REQ-020 SHALL have at least one IDLE cycle between phrases; a back-to-back phrase SHALL be granted the cycle after IDLE.
REQ-021 Packet counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-022 Timeout counter SHALL clear on grant entry and on every accepted beat, and SHALL increment each GRANTx cycle with sx_valid=0.
REQ-023 SHALL go to FLUSH when the counter reaches TIMEOUT-1 with sx_valid still low.
REQ-024 Stall caused by m_ready=0 SHALL NOT count toward the timeout.
REQ-025 FLUSH: when the output register is free, SHALL emit m_data=8'h00, m_last=1, m_abort=1, m_src=x, set err_timeout, update the pointer to x, leave pkt_cntx unchanged, and go to IDLE.
REQ-026 m_abort SHALL be 0 on all normal beats.
REQ-027 If sx_valid and the timeout threshold coincide, the beat SHALL be accepted and no abort SHALL occur.

Reset
REQ-028 rst SHALL force FSM=IDLE, pointer=source 1 (so source 0 wins the first tie), m_valid=0, m_data=0, m_last=0, m_src=0, m_abort=0, pkt_cnt0=pkt_cnt1=0, err_timeout=0, timeout counter=0, and s0_ready=s1_ready=0.
REQ-029 rst mid-phrase SHALL discard the in-flight beat with no abort beat emitted.

Structure
REQ-030 Shared package SHALL hold the FSM state encoding, the ABORT_CHAR constant (8'h00) and the source-ID constants.
REQ-031 The round-robin pick logic SHALL be sub-module rr_pick2 (inputs req[1:0], ptr; output grant[1:0]); all other logic SHALL be flat.

Verification
REQ-032 Scenario: source 0 sends "ILOVEYOU" (8 beats, last on 'U'), m_ready=1 -> 8 beats on m_* starting 2 cycles after s0_valid, m_src=0, pkt_cnt0=1.
REQ-033 Scenario: both sources valid after reset, each with a 3-beat phrase -> source 0 phrase completes fully, 1 IDLE cycle, then source 1 phrase; no interleave; pkt_cnt0=pkt_cnt1=1.
REQ-034 Scenario: m_ready toggles 1,0,0,1 during a phrase -> m_* held constant while stalled, no beat lost or duplicated, no timeout.
REQ-035 Scenario: source 1 sends "lo" then idles for 16 cycles -> abort beat 8'h00 with m_last=1, m_abort=1, m_src=1; err_timeout=1; pkt_cnt1 unchanged; source 0 is granted next.
REQ-036 Scenario: 300 one-beat phrases from source 0 -> pkt_cnt0 saturates at 255.
REQ-037 Scenario: rst asserted for 1 cycle at the third beat of a phrase -> all outputs at reset values the next cycle and no abort beat.
